// File: rtl/cnet_reg_arb.sv
// cnet_reg_arb
//   Arbitrates register requests from the PCI target (requester 0) and the
//   DMA engine (requester 1) onto the CNET register FIFO. It tracks up to two
//   outstanding reads in an in-order tag FIFO and routes read completions,
//   read timeouts and error flags back to the requester that issued the read.
//   A RUN/HOLD/RECOVER mode machine suspends traffic while the CNET device
//   is being reprogrammed.
//
// Build option
//   CNET_REG_ARB_RR_EN : round-robin arbitration between the two requesters.
//                        When undefined, requester 0 always has priority.
//
// Ports
//   pclk, reset_n                   clock, asynchronous active-low reset
//   reqK_req/we/addr/data (K=0,1)   request valid, write-not-read, address,
//                                   write data (held until granted)
//   reqK_grant                      combinational acceptance pulse
//   reqK_rd_vld/rd_data/rd_err      read return, read data, read timeout
//   p2n_req/we/addr/data            registered request into the CNET FIFO
//   p2n_almost_full                 downstream backpressure
//   n2p_rd_rdy, n2p_data            read completion from CNET
//   cnet_rd_timeout, cnet_reprog    timeout pulse, reprogram level
//   err_unexp_rd                    sticky: completion with no read pending
module cnet_reg_arb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 27,
  parameter int RECOVER_CYC = 8
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              req0_req,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_grant,
  output logic              req0_rd_vld,
  output logic [DATA_W-1:0] req0_rd_data,
  output logic              req0_rd_err,
  input  logic              req1_req,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_grant,
  output logic              req1_rd_vld,
  output logic [DATA_W-1:0] req1_rd_data,
  output logic              req1_rd_err,
  output logic              p2n_req,
  output logic              p2n_we,
  output logic [ADDR_W-1:0] p2n_addr,
  output logic [DATA_W-1:0] p2n_data,
  input  logic              p2n_almost_full,
  input  logic              n2p_rd_rdy,
  input  logic [DATA_W-1:0] n2p_data,
  input  logic              cnet_rd_timeout,
  input  logic              cnet_reprog,
  output logic              err_unexp_rd
);

  localparam int CNT_W = (RECOVER_CYC < 2) ? 1 : $clog2(RECOVER_CYC + 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYC);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic [1:0]        tag_q, tag_d;          // tag_q[0] is the oldest read
  logic              last_rd_id_q, last_rd_id_d;
  logic              p2n_req_q, p2n_req_d;
  logic              p2n_we_q, p2n_we_d;
  logic [ADDR_W-1:0] p2n_addr_q, p2n_addr_d;
  logic [DATA_W-1:0] p2n_data_q, p2n_data_d;
  logic [1:0]        rd_vld_q, rd_vld_d;
  logic [1:0]        rd_err_q, rd_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_unexp_q, err_unexp_d;

  logic run_s, pop_s, rd_room_s, elig0_s, elig1_s;
  logic gnt0_s, gnt1_s, push_s, flush_s;

`ifdef CNET_REG_ARB_RR_EN
  logic prio_q, prio_d;                     // 1: requester 1 wins a tie
`endif

  // Eligibility, completion pop qualification and arbitration
  always_comb begin
    run_s     = (state_q == ST_RUN);
    pop_s     = n2p_rd_rdy && run_s && (rd_cnt_q != 2'd0);
    // A completion popping this cycle frees a slot for a read granted now.
    rd_room_s = (rd_cnt_q < 2'd2) || pop_s;
    // reset_n gates the combinational grants so they read 0 during reset.
    elig0_s   = reset_n && req0_req && run_s && !p2n_almost_full && (req0_we || rd_room_s);
    elig1_s   = reset_n && req1_req && run_s && !p2n_almost_full && (req1_we || rd_room_s);
`ifdef CNET_REG_ARB_RR_EN
    gnt0_s    = elig0_s && (!elig1_s || !prio_q);
    gnt1_s    = elig1_s && (!elig0_s || prio_q);
`else
    gnt0_s    = elig0_s;
    gnt1_s    = elig1_s && !elig0_s;
`endif
    push_s    = (gnt0_s && !req0_we) || (gnt1_s && !req1_we);
    flush_s   = run_s && cnet_reprog;
  end

  // Mode sequencing: RUN -> HOLD on reprogram, HOLD -> RECOVER on release, RECOVER -> RUN after the idle count
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_RUN: begin
        if (cnet_reprog) state_d = ST_HOLD;
        else             state_d = ST_RUN;
      end
      ST_HOLD: begin
        if (!cnet_reprog) begin
          state_d = ST_RECOVER;
          rcnt_d  = RECOVER_LOAD;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RECOVER: begin
        // Leaving as the count steps to zero keeps RECOVER exactly RECOVER_CYC cycles long.
        if (cnet_reprog) begin
          state_d = ST_HOLD;
        end else if (rcnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  // In-order read tag FIFO (2 entries) and outstanding-read count
  always_comb begin
    tag_d    = tag_q;
    rd_cnt_d = rd_cnt_q;
    if (flush_s) begin
      tag_d    = 2'b00;
      rd_cnt_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (rd_cnt_q == 2'd0) tag_d[0] = gnt1_s;
          else                  tag_d[1] = gnt1_s;
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
        2'b01: begin
          tag_d    = {1'b0, tag_q[1]};
          rd_cnt_d = rd_cnt_q - 2'd1;
        end
        2'b11: begin
          // Head leaves, new tag goes in behind whatever remains.
          if (rd_cnt_q == 2'd1) tag_d = {1'b0, gnt1_s};
          else                  tag_d = {gnt1_s, tag_q[1]};
        end
        default: begin
          tag_d    = tag_q;
          rd_cnt_d = rd_cnt_q;
        end
      endcase
    end
  end

  // Read return, timeout routing, error flag and request forwarding
  always_comb begin
    last_rd_id_d = last_rd_id_q;
    rd_data_d    = rd_data_q;
    if (pop_s) begin
      rd_vld_d     = tag_q[0] ? 2'b10 : 2'b01;
      rd_data_d    = n2p_data;
      last_rd_id_d = tag_q[0];
    end else begin
      rd_vld_d     = 2'b00;
    end
    if (cnet_rd_timeout) rd_err_d = last_rd_id_q ? 2'b10 : 2'b01;
    else                 rd_err_d = 2'b00;
    // Completions outside RUN are dropped without flagging.
    err_unexp_d = err_unexp_q || (n2p_rd_rdy && run_s && (rd_cnt_q == 2'd0));

    p2n_req_d  = (gnt0_s || gnt1_s) && !flush_s;
    p2n_we_d   = p2n_we_q;
    p2n_addr_d = p2n_addr_q;
    p2n_data_d = p2n_data_q;
    if (gnt1_s) begin
      p2n_we_d   = req1_we;
      p2n_addr_d = req1_addr;
      p2n_data_d = req1_data;
    end else if (gnt0_s) begin
      p2n_we_d   = req0_we;
      p2n_addr_d = req0_addr;
      p2n_data_d = req0_data;
    end else begin
      p2n_we_d   = p2n_we_q;
    end
  end

  // State, tag FIFO, forwarded request and return-path registers
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      rcnt_q       <= '0;
      rd_cnt_q     <= 2'd0;
      tag_q        <= 2'b00;
      last_rd_id_q <= 1'b0;
      p2n_req_q    <= 1'b0;
      p2n_we_q     <= 1'b0;
      p2n_addr_q   <= '0;
      p2n_data_q   <= '0;
      rd_vld_q     <= 2'b00;
      rd_err_q     <= 2'b00;
      rd_data_q    <= '0;
      err_unexp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      rd_cnt_q     <= rd_cnt_d;
      tag_q        <= tag_d;
      last_rd_id_q <= last_rd_id_d;
      p2n_req_q    <= p2n_req_d;
      p2n_we_q     <= p2n_we_d;
      p2n_addr_q   <= p2n_addr_d;
      p2n_data_q   <= p2n_data_d;
      rd_vld_q     <= rd_vld_d;
      rd_err_q     <= rd_err_d;
      rd_data_q    <= rd_data_d;
      err_unexp_q  <= err_unexp_d;
    end
  end

`ifdef CNET_REG_ARB_RR_EN
  // Round-robin pointer: priority passes to the requester not just granted
  always_comb begin
    if (gnt0_s)      prio_d = 1'b1;
    else if (gnt1_s) prio_d = 1'b0;
    else             prio_d = prio_q;
  end

  // Round-robin pointer register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) prio_q <= 1'b0;
    else          prio_q <= prio_d;
  end
`endif

  assign req0_grant   = gnt0_s;
  assign req1_grant   = gnt1_s;
  assign req0_rd_vld  = rd_vld_q[0];
  assign req1_rd_vld  = rd_vld_q[1];
  // Read data is shared; each requester qualifies it with its own rd_vld.
  assign req0_rd_data = rd_data_q;
  assign req1_rd_data = rd_data_q;
  assign req0_rd_err  = rd_err_q[0];
  assign req1_rd_err  = rd_err_q[1];
  assign p2n_req      = p2n_req_q;
  assign p2n_we       = p2n_we_q;
  assign p2n_addr     = p2n_addr_q;
  assign p2n_data     = p2n_data_q;
  assign err_unexp_rd = err_unexp_q;

endmodule
